// File: rtl/enlynx_readout.sv
// enlynx_readout: snapshots enlynx counters on end-of-period and streams them
// as a framed valid/ready word sequence. Optional trailer: ENLYNX_READOUT_CHECKSUM_EN.
module enlynx_readout #(
  parameter int N_METRICS     = 2,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_METRICS*COUNTER_WIDTH-1:0] counters_i,
  input  logic [N_METRICS-1:0]               overflow_i,
  input  logic                               eop_i,
  output logic [COUNTER_WIDTH-1:0]           data_o,
  output logic                               valid_o,
  output logic                               last_o,
  input  logic                               ready_i,
  output logic                               busy_o
);

  localparam int IW = (N_METRICS > 1) ? $clog2(N_METRICS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_METRICS - 1);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    CHK
  } state_t;

  state_t                                  state_q;
  logic [IW-1:0]                           idx_q;
  logic [N_METRICS-1:0][COUNTER_WIDTH-1:0] shadow_q;
  logic [N_METRICS-1:0]                    ovf_q;
  logic [7:0]                              seq_q;
  logic [7:0]                              drop_q;
  logic [7:0]                              hdr_seq_q;
  logic [7:0]                              hdr_drop_q;

  logic [COUNTER_WIDTH-1:0] hdr_w;
  logic                     xfer;
  logic                     last_word;
  logic                     accept;

  assign valid_o = (state_q != IDLE);
  assign busy_o  = (state_q != IDLE);
  assign xfer    = valid_o & ready_i;

`ifdef ENLYNX_READOUT_CHECKSUM_EN
  logic [COUNTER_WIDTH-1:0] chk_w;
  assign last_word = (state_q == CHK);
`else
  assign last_word = (state_q == DATA) && (idx_q == LAST_IDX);
`endif

  assign last_o = last_word;
  assign accept = eop_i & ((state_q == IDLE) | (xfer & last_word));

  // Build the header word from the values latched at accept time.
  always_comb begin
    hdr_w                  = '0;
    hdr_w[31:24]           = hdr_seq_q;
    hdr_w[23:16]           = hdr_drop_q;
    hdr_w[N_METRICS-1:0]   = ovf_q;
  end

`ifdef ENLYNX_READOUT_CHECKSUM_EN
  // Trailer folds the header and every shadowed counter together.
  always_comb begin
    chk_w = hdr_w;
    for (int k = 0; k < N_METRICS; k++) begin
      chk_w = chk_w ^ shadow_q[k];
    end
  end
`endif

  // Select the outgoing word from registered state only.
  always_comb begin
    data_o = '0;
    unique case (state_q)
      HDR:  data_o = hdr_w;
      DATA: data_o = shadow_q[idx_q];
`ifdef ENLYNX_READOUT_CHECKSUM_EN
      CHK:  data_o = chk_w;
`endif
      default: data_o = '0;
    endcase
  end

  // Snapshot, sequence/drop bookkeeping and frame sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shadow_q   <= '0;
      ovf_q      <= '0;
      seq_q      <= '0;
      drop_q     <= '0;
      hdr_seq_q  <= '0;
      hdr_drop_q <= '0;
    end else begin
      if (accept) begin
        shadow_q   <= counters_i;
        ovf_q      <= overflow_i;
        hdr_seq_q  <= seq_q;
        seq_q      <= seq_q + 8'd1;
        hdr_drop_q <= drop_q;
        drop_q     <= '0;
      end else if (eop_i && drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) state_q <= HDR;
        end
        HDR: begin
          if (xfer) begin
            idx_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            if (idx_q == LAST_IDX) begin
`ifdef ENLYNX_READOUT_CHECKSUM_EN
              state_q <= CHK;
`else
              state_q <= accept ? HDR : IDLE;
`endif
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        CHK: begin
`ifdef ENLYNX_READOUT_CHECKSUM_EN
          if (xfer) state_q <= accept ? HDR : IDLE;
`else
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enlynx_readout.sv
// tb_enlynx_readout: directed checks of framing, backpressure, drops,
// back-to-back frames, sequence wrap and asynchronous reset.
module tb_enlynx_readout;

`ifdef ENLYNX_READOUT_CHECKSUM_EN
  localparam int NW = 4;
`else
  localparam int NW = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] counters_i = '0;
  logic [1:0]  overflow_i = '0;
  logic        eop_i = 1'b0;
  logic [31:0] data_o;
  logic        valid_o;
  logic        last_o;
  logic        ready_i = 1'b0;
  logic        busy_o;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_w [4] = '{32'h0000_0002, 32'h3, 32'h5, 32'h0000_0004};

  enlynx_readout #(.N_METRICS(2), .COUNTER_WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .counters_i(counters_i),
    .overflow_i(overflow_i),
    .eop_i(eop_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .last_o(last_o),
    .ready_i(ready_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hdr(input logic [7:0] s, input logic [7:0] d);
    return {s, d, 16'h0002};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    eop_i = 1'b0;
    ready_i = 1'b0;
    counters_i = {32'h5, 32'h3};
    overflow_i = 2'b10;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_eop();
    eop_i = 1'b1;
    @(negedge clk);
    eop_i = 1'b0;
  endtask

  task automatic get_word(output logic [31:0] d, output logic l, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    d = '0;
    l = 1'b0;
    ready_i = 1'b0;
    while (!valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!valid_o) return;
    d = data_o;
    l = last_o;
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    ok = 1'b1;
  endtask

  task automatic drain(input int n, output int got);
    logic [31:0] d;
    logic        l;
    bit          ok;
    got = 0;
    for (int i = 0; i < n; i++) begin
      get_word(d, l, ok);
      if (ok) got++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({valid_o, last_o, busy_o} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 000", {valid_o, last_o, busy_o});
    end
    tests++;
    if (data_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_data got %h want 0", data_o);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic        l;
    bit          ok;
    do_reset();
    pulse_eop();
    tests++;
    if (valid_o !== 1'b1 || data_o !== 32'h0000_0002) begin
      fails++;
      $display("FAIL basic_latency got v=%b d=%h want v=1 d=00000002", valid_o, data_o);
    end
    for (int i = 0; i < NW; i++) begin
      get_word(d, l, ok);
      tests++;
      if (!ok || d !== exp_w[i] || l !== (i == NW - 1)) begin
        fails++;
        $display("FAIL basic_w%0d got ok=%b d=%h l=%b want d=%h l=%b",
                 i, ok, d, l, exp_w[i], (i == NW - 1));
      end
    end
    tests++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle got v=%b b=%b want 0 0", valid_o, busy_o);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0;
    logic        l0;
    int          n;
    bit          stable;
    do_reset();
    pulse_eop();
    for (int i = 0; i < NW; i++) begin
      n = 0;
      while (!valid_o && n < 50) begin
        @(negedge clk);
        n++;
      end
      d0 = data_o;
      l0 = last_o;
      if (i == 0) counters_i = {2{32'hFFFF_FFFF}};
      stable = 1'b1;
      ready_i = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (valid_o !== 1'b1 || data_o !== d0 || last_o !== l0) stable = 1'b0;
      end
      tests++;
      if (!stable) begin
        fails++;
        $display("FAIL bp_stable_w%0d got v=%b d=%h want v=1 d=%h", i, valid_o, data_o, d0);
      end
      tests++;
      if (d0 !== exp_w[i] || l0 !== (i == NW - 1)) begin
        fails++;
        $display("FAIL bp_w%0d got d=%h l=%b want d=%h l=%b", i, d0, l0, exp_w[i], (i == NW - 1));
      end
      ready_i = 1'b1;
      @(negedge clk);
      ready_i = 1'b0;
    end
  endtask

  task automatic test_drops();
    logic [31:0] d;
    logic        l;
    bit          ok;
    int          got;
    do_reset();
    pulse_eop();
    repeat (3) begin
      @(negedge clk);
      pulse_eop();
    end
    drain(NW, got);
    pulse_eop();
    get_word(d, l, ok);
    tests++;
    if (!ok || d !== hdr(8'd1, 8'd3)) begin
      fails++;
      $display("FAIL drops_hdr got ok=%b d=%h want %h", ok, d, hdr(8'd1, 8'd3));
    end
    drain(NW - 1, got);
    pulse_eop();
    get_word(d, l, ok);
    tests++;
    if (!ok || d !== hdr(8'd2, 8'd0)) begin
      fails++;
      $display("FAIL drops_clear got ok=%b d=%h want %h", ok, d, hdr(8'd2, 8'd0));
    end
    drain(NW - 1, got);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        l;
    bit          ok;
    int          got;
    do_reset();
    pulse_eop();
    drain(NW - 1, got);
    tests++;
    if (valid_o !== 1'b1 || last_o !== 1'b1) begin
      fails++;
      $display("FAIL b2b_last got v=%b l=%b want 1 1", valid_o, last_o);
    end
    ready_i = 1'b1;
    eop_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    eop_i = 1'b0;
    tests++;
    if (valid_o !== 1'b1 || data_o !== hdr(8'd1, 8'd0)) begin
      fails++;
      $display("FAIL b2b_hdr got v=%b d=%h want v=1 d=%h", valid_o, data_o, hdr(8'd1, 8'd0));
    end
    drain(NW, got);
    pulse_eop();
    get_word(d, l, ok);
    tests++;
    if (!ok || d !== hdr(8'd2, 8'd0)) begin
      fails++;
      $display("FAIL b2b_nodrop got ok=%b d=%h want %h", ok, d, hdr(8'd2, 8'd0));
    end
    drain(NW - 1, got);
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    logic        l;
    bit          ok;
    int          got;
    do_reset();
    pulse_eop();
    eop_i = 1'b1;
    repeat (300) @(negedge clk);
    eop_i = 1'b0;
    drain(NW, got);
    pulse_eop();
    get_word(d, l, ok);
    tests++;
    if (!ok || d !== hdr(8'd1, 8'hFF)) begin
      fails++;
      $display("FAIL sat_hdr got ok=%b d=%h want %h", ok, d, hdr(8'd1, 8'hFF));
    end
    drain(NW - 1, got);
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic        l;
    bit          ok;
    int          got;
    do_reset();
    for (int f = 1; f <= 257; f++) begin
      pulse_eop();
      get_word(d, l, ok);
      if (f == 256) begin
        tests++;
        if (!ok || d !== hdr(8'hFF, 8'd0)) begin
          fails++;
          $display("FAIL wrap_255 got ok=%b d=%h want %h", ok, d, hdr(8'hFF, 8'd0));
        end
      end
      if (f == 257) begin
        tests++;
        if (!ok || d !== hdr(8'h00, 8'd0)) begin
          fails++;
          $display("FAIL wrap_0 got ok=%b d=%h want %h", ok, d, hdr(8'h00, 8'd0));
        end
      end
      drain(NW - 1, got);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        l;
    bit          ok;
    int          got;
    do_reset();
    repeat (2) begin
      pulse_eop();
      drain(NW, got);
    end
    pulse_eop();
    get_word(d, l, ok);
    tests++;
    if (valid_o !== 1'b1 || data_o !== 32'h3) begin
      fails++;
      $display("FAIL rmid_pre got v=%b d=%h want v=1 d=00000003", valid_o, data_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL rmid_async got v=%b b=%b want 0 0", valid_o, busy_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_eop();
    get_word(d, l, ok);
    tests++;
    if (!ok || d !== hdr(8'd0, 8'd0)) begin
      fails++;
      $display("FAIL rmid_hdr got ok=%b d=%h want %h", ok, d, hdr(8'd0, 8'd0));
    end
    drain(NW - 1, got);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_drops();
    test_back_to_back();
    test_saturation();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
